mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameters: NB_DATA, default 32, data width; NB_REG, default 5, register index width; NB_DEPTH, default 8, log2 of data-memory depth in words.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-low
- i_step  in  1  stall; high holds all state
- i_mem2reg  in  1  load-result select
- i_memWrite  in  1  store request
- i_regWrite  in  1  writeback enable
- i_width  in  2  00 byte, 01 half, 11 word, 10 treated as word
- i_sign_flag  in  1  1 sign-extend load, 0 zero-extend
- i_result  in  NB_DATA  ALU result; byte address
- i_data4Mem  in  NB_DATA  store data
- i_write_reg  in  NB_REG  destination register
- i_dbg_addr  in  NB_DEPTH  debug word address
- o_mem2reg  out  1  registered
- o_regWrite  out  1  registered, gated by misalignment
- o_write_reg  out  NB_REG  registered
- o_result  out  NB_DATA  registered ALU passthrough
- o_read_data  out  NB_DATA  registered, extended load data
- o_misaligned  out  1  registered fault flag
- o_dbg_data  out  NB_DATA  registered debug read word

Function
REQ-003 SHALL implement 2**NB_DEPTH x NB_DATA word memory indexed by i_result[NB_DEPTH+1:2], little-endian byte lanes selected by i_result[1:0].
REQ-004 SHALL flag misaligned when half with i_result[0]=1, or word (11/10) with i_result[1:0]!=00; byte never misaligned.
REQ-005 SHALL write on posedge when i_memWrite=1, i_step=0, not misaligned; byte writes only lane i_result[1:0] with i_data4Mem[7:0], half writes lanes {a1,0} and {a1,1} with i_data4Mem[15:0], word writes all lanes.
REQ-006 SHALL suppress the store entirely when misaligned; memory unchanged.
REQ-007 SHALL read the addressed word synchronously, read-before-write, and register lane-extracted data into o_read_data at the same edge; latency 1 cycle from inputs to all outputs.
REQ-008 SHALL extend byte/half loads per i_sign_flag: sign=1 replicates bit 7/15, sign=0 pads zeros; word loads pass unmodified.
REQ-009 SHALL drive o_read_data=0 and o_regWrite=0 for a misaligned access with i_mem2reg=1; o_misaligned=1 for one cycle for any misaligned access with i_mem2reg or i_memWrite set.
REQ-010 SHALL compute o_read_data regardless of i_mem2reg; o_result=i_result registered.
REQ-011 SHALL, while i_step=1, hold all outputs except o_dbg_data and perform no store.
REQ-012 SHALL update o_dbg_data every cycle with mem[i_dbg_addr], independent of i_step; same-cycle store to same word returns old data.
REQ-013 SHALL make a store visible to a load or debug read issued on the following cycle.

Reset
REQ-014 SHALL on i_reset=0 asynchronously clear o_mem2reg, o_regWrite, o_misaligned, o_write_reg, o_result, o_read_data, o_dbg_data to 0.
REQ-015 SHALL leave memory contents unchanged by reset; a store in the reset cycle is dropped.
REQ-016 SHALL resume normal operation on the first posedge after i_reset deasserts.

Structure
REQ-017 SHALL place width encodings (BYTE=00, HALF=01, WORD=11) and default depth in shared package cpu_pkg.
REQ-018 SHALL isolate lane selection, store byte-enable generation, extension and misalignment detection in combinational sub-module mem_lane_align.

Verification
REQ-019 Word store 0xDEADBEEF @0x10, word load @0x10 next cycle -> o_read_data=0xDEADBEEF, o_misaligned=0.
REQ-020 Byte store 0x80 @0x13 over word 0 then load byte @0x13 sign=1 -> 0xFFFFFF80; sign=0 -> 0x00000080; word @0x10 -> 0x80000000.
REQ-021 Half load @0x11 with i_mem2reg=1, i_regWrite=1 -> o_misaligned=1, o_regWrite=0, o_read_data=0; word store @0x12 -> memory unchanged.
REQ-022 Store with i_step=1 for 3 cycles -> memory and outputs unchanged; release -> store lands, outputs update next edge.
REQ-023 i_dbg_addr=4 with concurrent word store 0x12345678 @0x10 -> o_dbg_data old value that cycle, 0x12345678 next cycle.
REQ-024 Reset asserted mid-stream -> outputs 0 immediately without clock edge; previously stored word still readable after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory access width encodings, default data-memory depth
// and the alignment rule used by the load/store path.
package cpu_pkg;

   localparam logic [1:0] WIDTH_BYTE = 2'b00;
   localparam logic [1:0] WIDTH_HALF = 2'b01;
   localparam logic [1:0] WIDTH_WORD = 2'b11;

   localparam int DEFAULT_DEPTH  = 8;
   localparam int BYTES_PER_WORD = 4;

   // Encoding 2'b10 is not a legal width and is handled exactly like a word.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
      logic fault;
      case (width)
         WIDTH_BYTE: fault = 1'b0;
         WIDTH_HALF: fault = addr_lo[0];
         default:    fault = (addr_lo != 2'b00);
      endcase
      return fault;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the data memory: store lane enables and
// replicated store data, load lane extraction with sign/zero extension, alignment check.
module mem_lane_align
   import cpu_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [1:0]                width,
   input  logic [1:0]                addr_lo,
   input  logic                      sign_flag,
   input  logic [NB_DATA-1:0]        store_data,
   input  logic [NB_DATA-1:0]        rd_word,
   output logic                      misaligned,
   output logic [BYTES_PER_WORD-1:0] byte_en,
   output logic [NB_DATA-1:0]        wr_word,
   output logic [NB_DATA-1:0]        load_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign misaligned = is_misaligned(width, addr_lo);

   assign ld_byte = rd_word[{addr_lo, 3'b000} +: 8];
   assign ld_half = rd_word[{addr_lo[1], 4'b0000} +: 16];

   // A misaligned access must never touch memory, so every lane is masked here.
   for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign byte_en[gi] = !misaligned &&
                           ((width == WIDTH_BYTE) ? (addr_lo == 2'(gi)) :
                            (width == WIDTH_HALF) ? (addr_lo[1] == 1'(gi / 2)) :
                                                    1'b1);
   end

   // Store data is replicated across lanes; byte_en picks which copy lands.
   always_comb begin
      wr_word = store_data;
      case (width)
         WIDTH_BYTE: wr_word = {(NB_DATA / 8){store_data[7:0]}};
         WIDTH_HALF: wr_word = {(NB_DATA / 16){store_data[15:0]}};
         default:    wr_word = store_data;
      endcase
   end

   always_comb begin
      load_data = rd_word;
      case (width)
         WIDTH_BYTE: load_data = {{(NB_DATA - 8){sign_flag & ld_byte[7]}}, ld_byte};
         WIDTH_HALF: load_data = {{(NB_DATA - 16){sign_flag & ld_half[15]}}, ld_half};
         default:    load_data = rd_word;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte-addressed data memory with byte/half/word load/store,
// misalignment trapping, stall hold and an independent debug read port.
module mem_access_stage
   import cpu_pkg::*;
#(
   parameter int NB_DATA  = 32,
   parameter int NB_REG   = 5,
   parameter int NB_DEPTH = DEFAULT_DEPTH
) (
   input  logic                clk,
   input  logic                i_reset,
   input  logic                i_step,
   input  logic                i_mem2reg,
   input  logic                i_memWrite,
   input  logic                i_regWrite,
   input  logic [1:0]          i_width,
   input  logic                i_sign_flag,
   input  logic [NB_DATA-1:0]  i_result,
   input  logic [NB_DATA-1:0]  i_data4Mem,
   input  logic [NB_REG-1:0]   i_write_reg,
   input  logic [NB_DEPTH-1:0] i_dbg_addr,
   output logic                o_mem2reg,
   output logic                o_regWrite,
   output logic [NB_REG-1:0]   o_write_reg,
   output logic [NB_DATA-1:0]  o_result,
   output logic [NB_DATA-1:0]  o_read_data,
   output logic                o_misaligned,
   output logic [NB_DATA-1:0]  o_dbg_data
);

   logic [NB_DATA-1:0]        mem [2**NB_DEPTH];
   logic [NB_DEPTH-1:0]       word_addr;
   logic [NB_DATA-1:0]        rd_word;
   logic [NB_DATA-1:0]        wr_word;
   logic [NB_DATA-1:0]        load_data;
   logic [BYTES_PER_WORD-1:0] byte_en;
   logic                      misaligned;
   logic                      store_en;
   logic                      load_fault;

   // Address bits above the memory window are ignored (memory wraps).
   logic unused_addr_bits;
   assign unused_addr_bits = ^i_result[NB_DATA-1:NB_DEPTH+2];

   assign word_addr = i_result[NB_DEPTH+1:2];
   assign rd_word   = mem[word_addr];

   mem_lane_align #(
      .NB_DATA (NB_DATA)
   ) u_align (
      .width      (i_width),
      .addr_lo    (i_result[1:0]),
      .sign_flag  (i_sign_flag),
      .store_data (i_data4Mem),
      .rd_word    (rd_word),
      .misaligned (misaligned),
      .byte_en    (byte_en),
      .wr_word    (wr_word),
      .load_data  (load_data)
   );

   assign store_en   = i_memWrite && !i_step;
   assign load_fault = misaligned && i_mem2reg;

   // Memory has no reset; a store presented while reset is held is simply dropped.
   always_ff @(posedge clk) begin
      if (i_reset && store_en) begin
         for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (byte_en[i]) begin
               mem[word_addr][i*8 +: 8] <= wr_word[i*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         o_mem2reg    <= 1'b0;
         o_regWrite   <= 1'b0;
         o_write_reg  <= '0;
         o_result     <= '0;
         o_read_data  <= '0;
         o_misaligned <= 1'b0;
      end else if (!i_step) begin
         o_mem2reg    <= i_mem2reg;
         o_regWrite   <= i_regWrite && !load_fault;
         o_write_reg  <= i_write_reg;
         o_result     <= i_result;
         o_read_data  <= load_fault ? '0 : load_data;
         o_misaligned <= misaligned && (i_mem2reg || i_memWrite);
      end
   end

   // Debug port keeps sampling during stalls so a debugger can inspect a frozen core.
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         o_dbg_data <= '0;
      end else begin
         o_dbg_data <= mem[i_dbg_addr];
      end
   end

endmodule
